// File: rtl/cart_rom_fetch.sv
// cart_rom_fetch: synchronizes the cartridge read, fetches the banked byte from NOR flash
// and serves re-reads of the same address from a one-entry tag.
module cart_rom_fetch #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ACCESS_CYCLES = 6
) (
    input  logic        sys_clock,
    input  logic        sys_reset,
    input  logic [15:0] Cart_a,
    input  logic        Cart_nRD,
    input  logic [8:0]  Rom_a,
    input  logic        Rom_nCS,
    output logic [22:0] Flash_a,
    output logic        Flash_nCE,
    output logic        Flash_nOE,
    input  logic [7:0]  Flash_d,
    output logic [7:0]  Cart_d_out,
    output logic        Cart_d_oe
);
    typedef enum logic [1:0] {IDLE, SETTLE, ACCESS} state_t;
    localparam logic [3:0] SET_N = 4'(SETTLE_CYCLES);
    localparam logic [3:0] ACC_N = 4'(ACCESS_CYCLES);
    state_t state, state_nx;
    logic [22:0] a_meta, s_a, ref_a, ref_nx, fa_nx, tag_addr, tag_nx;
    logic        cs_meta, s_cs, rd_meta, s_rd;
    logic [3:0]  cnt, cnt_nx, cnt_inc;
    logic        tag_valid, tv_nx, active, hit, oe_nx;
    logic [7:0]  data_reg, data_nx;
    logic        unused_cart_a;
    assign unused_cart_a = &{1'b0, Cart_a[15:14]};
    assign active  = !s_rd && !s_cs;
    assign hit     = tag_valid && tag_addr == s_a;
    assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;
    assign oe_nx   = active && hit && state == IDLE;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ref_nx   = ref_a;
        fa_nx    = Flash_a;
        tag_nx   = tag_addr;
        tv_nx    = tag_valid;
        data_nx  = data_reg;
        case (state)
            IDLE: if (active && !hit) begin
                state_nx = SETTLE;
                cnt_nx   = 4'd1;
                ref_nx   = s_a;
            end
            SETTLE: if (!active) state_nx = IDLE;
            else if (s_a != ref_a) begin
                ref_nx = s_a;
                cnt_nx = 4'd1;
            end else if (cnt >= SET_N) begin
                state_nx = ACCESS;
                fa_nx    = ref_a;
                cnt_nx   = 4'd1;
            end else cnt_nx = cnt_inc;
            ACCESS: if (!active || s_a != Flash_a) state_nx = IDLE;
            else if (cnt >= ACC_N) begin
                data_nx  = Flash_d;
                tag_nx   = Flash_a;
                tv_nx    = 1'b1;
                state_nx = IDLE;
            end else cnt_nx = cnt_inc;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            a_meta     <= '0;
            s_a        <= '0;
            cs_meta    <= 1'b1;
            s_cs       <= 1'b1;
            rd_meta    <= 1'b1;
            s_rd       <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            ref_a      <= '0;
            Flash_a    <= '0;
            Flash_nCE  <= 1'b1;
            Flash_nOE  <= 1'b1;
            tag_addr   <= '0;
            tag_valid  <= 1'b0;
            data_reg   <= 8'hFF;
            Cart_d_out <= 8'hFF;
            Cart_d_oe  <= 1'b0;
        end else begin
            a_meta     <= {Rom_a, Cart_a[13:0]};
            s_a        <= a_meta;
            cs_meta    <= Rom_nCS;
            s_cs       <= cs_meta;
            rd_meta    <= Cart_nRD;
            s_rd       <= rd_meta;
            state      <= state_nx;
            cnt        <= cnt_nx;
            ref_a      <= ref_nx;
            Flash_a    <= fa_nx;
            Flash_nCE  <= state_nx != ACCESS;
            Flash_nOE  <= state_nx != ACCESS;
            tag_addr   <= tag_nx;
            tag_valid  <= tv_nx;
            data_reg   <= data_nx;
            Cart_d_oe  <= oe_nx;
            if (oe_nx) Cart_d_out <= data_reg;
        end
    end
endmodule

// File: doc/cart_rom_fetch.md
# cart_rom_fetch

Read-side datapath for the cartridge ROM window. It sits directly downstream of the bank mapper: it takes the mapper's banked upper address (Rom_a[22:14], Rom_nCS) and the cartridge low address, and fetches the byte from the external parallel NOR flash. It then presents that byte for the top level to drive onto Cart_d while the console holds the read. A one-entry tag avoids re-fetching when the console re-reads the same location.

## Interface
- SETTLE_CYCLES, 2: consecutive identical synchronized address samples required before a fetch launches (1..15).
- ACCESS_CYCLES, 6: cycles Flash_nCE/Flash_nOE are held low before Flash_d is captured (1..15).
- sys_clock  in  1  system clock; all logic on rising edge.
- sys_reset  in  1  synchronous, active-high reset.
- Cart_a  in  16  cartridge address; only [13:0] used.
- Cart_nRD  in  1  cartridge read strobe, active low, asynchronous.
- Rom_a  in  9  banked address bits [22:14] from the mapper.
- Rom_nCS  in  1  mapper ROM select, active low.
- Flash_a  out  23  flash byte address.
- Flash_nCE  out  1  flash chip enable, active low.
- Flash_nOE  out  1  flash output enable, active low.
- Flash_d  in  8  flash read data.
- Cart_d_out  out  8  byte to drive on Cart_d.
- Cart_d_oe  out  1  Cart_d drive enable; the top level tri-states Cart_d when low.

## Operation
- Input sampling:
  - The composite address A = {Rom_a, Cart_a[13:0]} (23 bits), Rom_nCS and Cart_nRD pass through 2-flop synchronizers.
  - Downstream logic sees only synced values: sA, s_cs, s_rd.
  - A read is active when s_rd == 0 and s_cs == 0.
- Tag: tag_addr (23 bits), tag_valid and data_reg (8 bits).
  - On reset: tag_valid = 0, data_reg = 8'hFF.
  - A hit means tag_valid && tag_addr == sA.
- States:
  - IDLE
    - Active read and hit: stay in IDLE (serve from data_reg).
    - Active read and miss: go to SETTLE, cnt = 1, ref = sA.
  - SETTLE
    - Read no longer active: go to IDLE.
    - sA != ref: ref = sA, cnt = 1.
    - Otherwise cnt++.
    - When cnt reaches SETTLE_CYCLES: go to ACCESS, Flash_a = ref, Flash_nCE = Flash_nOE = 0, cnt = 1.
  - ACCESS
    - sA != Flash_a, or read no longer active: abort. Deassert strobes, tag unchanged, go to IDLE (re-evaluates next cycle).
    - When cnt == ACCESS_CYCLES: data_reg = Flash_d, tag_addr = Flash_a, tag_valid = 1, strobes high, go to IDLE.
    - Otherwise cnt++.
- Output: Cart_d_oe = registered (read active && hit && state == IDLE). Cart_d_out = data_reg whenever Cart_d_oe = 1. It holds its last value otherwise.
- Rom_nCS high (RAM/IO window) never starts a fetch and never drives Cart_d.
- Bank switch with unchanged Cart_a changes sA. This is a miss and forces a refetch.
- Flash_a holds its last value outside ACCESS.

## Timing
- Reset values: Flash_a = 0, Flash_nCE = 1, Flash_nOE = 1, Cart_d_out = 8'hFF, Cart_d_oe = 0. FSM = IDLE, synchronizers preset to nRD = 1 and nCS = 1.
- Reset asserted mid-ACCESS: strobes go high on the next edge and tag_valid clears.
- Miss latency, counted from the edge where the input is stable with nRD low to the edge where Cart_d_oe = 1: 2 (sync) + 1 (IDLE decision) + SETTLE_CYCLES + ACCESS_CYCLES + 1 (oe register). Defaults give 12 cycles.
- Hit latency: 2 + 1 = 3 cycles.
- Cart_d_oe falls 3 cycles after Cart_nRD rises.
- Flash_nCE/Flash_nOE are low for exactly ACCESS_CYCLES consecutive cycles on a completed fetch. They are never low outside ACCESS.
- Flash_a is stable for the entire low period of the strobes.
- cnt is 4 bits and saturates; no wrap.

## Test plan
- Reset, then read A=0x0000 (Rom_a=0) with Flash_d=0x31 -> Flash strobes low 6 cycles at Flash_a=0x000000; Cart_d_oe=1 with Cart_d_out=0x31 at cycle 12.
- Release nRD, then re-read 0x0000 -> no strobe activity; Cart_d_oe=1 after 3 cycles, data 0x31. Cart_d_oe falls 3 cycles after each nRD rise.
- Rom_a=9'h005, Cart_a=0x4123 -> Flash_a=0x014123. Change Rom_a to 9'h006 while Cart_a is unchanged -> refetch at 0x018123.
- Cart_a changes from 0x4123 to 0x4124 in the 3rd ACCESS cycle -> abort, strobes high, new fetch at the new address, tag never holds 0x014123's partial data.
- Cart_a=0xA000 with Rom_nCS=1 and nRD low -> Flash_nCE stays 1, Cart_d_oe stays 0.
- sys_reset pulse during ACCESS -> strobes high next edge; a subsequent read of the previously cached address performs a full fetch.
